lp_burst_framer: RTL and testbench

Downstream consumer of the low-pass one-burst delay buffer. Takes its read stream (data, valid, sop), counts words into fixed-length bursts, and marks burst end (eop) and symbol index within the slot. It also detects truncated and orphan bursts, so the dimension-reduction datapath receives cleanly framed symbols. Output is a registered copy of the input stream plus framing sidebands, with 1-cycle latency.

---
 rtl/lp_pkg.sv | 8 +
 rtl/lp_sat_cnt.sv | 19 +
 rtl/lp_burst_framer.sv | 168 ++++++++++++++++
 tb/tb_lp_burst_framer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// Shared types and constants for the low-pass burst framer.
package lp_pkg;

  typedef enum logic {LP_IDLE, LP_RUN} lp_frm_state_t;

  localparam int LP_ERR_CNT_W = 16;

endpackage

// File: rtl/lp_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module lp_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/lp_burst_framer.sv
// Frames the delay-buffer read stream into fixed-length bursts with symbol index and error flags.
// Define LP_BURST_FRAMER_ERR_CNT_EN to build the saturating error counter behind o_err_cnt.
module lp_burst_framer
  import lp_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int BURST_LEN  = 64,
  parameter  int SYM_NUM    = 14,
  localparam int SYM_W      = (SYM_NUM > 1) ? $clog2(SYM_NUM) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH-1:0]   i_rx_data,
  input  logic                    i_rx_vld,
  input  logic                    i_rx_sop,
  output logic [DATA_WIDTH-1:0]   o_tx_data,
  output logic                    o_tx_vld,
  output logic                    o_tx_sop,
  output logic                    o_tx_eop,
  output logic [SYM_W-1:0]        o_sym_idx,
  output logic                    o_slot_done,
  output logic                    o_len_err,
  output logic                    o_orphan_err,
  output logic [LP_ERR_CNT_W-1:0] o_err_cnt
);

  localparam int              WC_W     = $clog2(BURST_LEN + 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_NUM - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(BURST_LEN - 1);
  localparam bit               SINGLE   = (BURST_LEN == 1);

  function automatic logic [SYM_W-1:0] sym_adv(input logic [SYM_W-1:0] s);
    return (s == SYM_LAST) ? '0 : s + 1'b1;
  endfunction

  lp_frm_state_t   state, state_d;
  logic [WC_W-1:0]  wcnt, wcnt_d;
  logic [SYM_W-1:0] sym_idx, sym_d, cur_sym;

  logic             vld_p0, sop_p0, eop_p0, slot_p0, len_p0, orph_p0;
  logic [SYM_W-1:0] idx_p0;

  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1, sop_p1, eop_p1, slot_p1, len_p1, orph_p1;
  logic [SYM_W-1:0]      idx_p1;

  // sym_idx holds the running burst's index in RUN and the next burst's index in IDLE
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= LP_IDLE;
      wcnt    <= '0;
      sym_idx <= '0;
    end else begin
      state   <= state_d;
      wcnt    <= wcnt_d;
      sym_idx <= sym_d;
    end
  end

  always_comb begin
    state_d = state;
    if (i_rx_vld) begin
      unique case (state)
        LP_IDLE: if (i_rx_sop && !SINGLE) state_d = LP_RUN;
        LP_RUN: begin
          if (i_rx_sop)            state_d = SINGLE ? LP_IDLE : LP_RUN;
          else if (wcnt == WC_LAST) state_d = LP_IDLE;
        end
        default: state_d = LP_IDLE;
      endcase
    end
  end

  always_comb begin
    vld_p0  = 1'b0;
    sop_p0  = 1'b0;
    eop_p0  = 1'b0;
    slot_p0 = 1'b0;
    len_p0  = 1'b0;
    orph_p0 = 1'b0;
    idx_p0  = idx_p1;
    wcnt_d  = wcnt;
    sym_d   = sym_idx;
    cur_sym = sym_idx;
    if (i_rx_vld) begin
      if (i_rx_sop) begin
        // An early sop retires the truncated burst as a consumed symbol, without eop
        if (state == LP_RUN) begin
          cur_sym = sym_adv(sym_idx);
          len_p0  = 1'b1;
        end
        vld_p0 = 1'b1;
        sop_p0 = 1'b1;
        idx_p0 = cur_sym;
        wcnt_d = WC_W'(1);
        sym_d  = cur_sym;
        if (SINGLE) begin
          eop_p0  = 1'b1;
          slot_p0 = (cur_sym == SYM_LAST);
          sym_d   = sym_adv(cur_sym);
        end
      end else if (state == LP_RUN) begin
        vld_p0 = 1'b1;
        idx_p0 = sym_idx;
        wcnt_d = wcnt + 1'b1;
        if (wcnt == WC_LAST) begin
          eop_p0  = 1'b1;
          slot_p0 = (sym_idx == SYM_LAST);
          sym_d   = sym_adv(sym_idx);
          wcnt_d  = '0;
        end
      end else begin
        orph_p0 = 1'b1;
      end
    end
  end

  // Output stage: one-cycle registered copy of the stream plus sidebands
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      slot_p1 <= 1'b0;
      len_p1  <= 1'b0;
      orph_p1 <= 1'b0;
      idx_p1  <= '0;
    end else begin
      data_p1 <= i_rx_data;
      vld_p1  <= vld_p0;
      sop_p1  <= sop_p0;
      eop_p1  <= eop_p0;
      slot_p1 <= slot_p0;
      len_p1  <= len_p0;
      orph_p1 <= orph_p0;
      idx_p1  <= idx_p0;
    end
  end

  assign o_tx_data    = data_p1;
  assign o_tx_vld     = vld_p1;
  assign o_tx_sop     = sop_p1;
  assign o_tx_eop     = eop_p1;
  assign o_sym_idx    = idx_p1;
  assign o_slot_done  = slot_p1;
  assign o_len_err    = len_p1;
  assign o_orphan_err = orph_p1;

`ifdef LP_BURST_FRAMER_ERR_CNT_EN
  logic err_inc;

  // Both flags in one cycle still count once
  assign err_inc = len_p0 | orph_p0;

  lp_sat_cnt #(
    .WIDTH (LP_ERR_CNT_W)
  ) u_err_cnt (
    .clk   (i_clk),
    .inc   (err_inc),
    .clear (i_reset),
    .value (o_err_cnt)
  );
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lp_burst_framer.sv
// Bench for lp_burst_framer: BURST_LEN=4/SYM_NUM=3 and BURST_LEN=1/SYM_NUM=1 instances on shared stimulus.
module tb_lp_burst_framer;

`ifdef LP_BURST_FRAMER_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vld, sop;
  logic [31:0] din;

  logic [31:0] a_data, b_data;
  logic        a_vld, a_sop, a_eop, a_slot, a_len, a_orph;
  logic        b_vld, b_sop, b_eop, b_slot, b_len, b_orph;
  logic [1:0]  a_idx;
  logic [0:0]  b_idx;
  logic [15:0] a_ecnt, b_ecnt;

  lp_burst_framer #(.DATA_WIDTH(32), .BURST_LEN(4), .SYM_NUM(3)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_rx_data(din), .i_rx_vld(vld), .i_rx_sop(sop),
    .o_tx_data(a_data), .o_tx_vld(a_vld), .o_tx_sop(a_sop), .o_tx_eop(a_eop),
    .o_sym_idx(a_idx), .o_slot_done(a_slot), .o_len_err(a_len),
    .o_orphan_err(a_orph), .o_err_cnt(a_ecnt)
  );

  lp_burst_framer #(.DATA_WIDTH(32), .BURST_LEN(1), .SYM_NUM(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_rx_data(din), .i_rx_vld(vld), .i_rx_sop(sop),
    .o_tx_data(b_data), .o_tx_vld(b_vld), .o_tx_sop(b_sop), .o_tx_eop(b_eop),
    .o_sym_idx(b_idx), .o_slot_done(b_slot), .o_len_err(b_len),
    .o_orphan_err(b_orph), .o_err_cnt(b_ecnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference: words seen in the open burst (0 = none open), symbol counter, error tally
  int bl [2] = '{4, 1};
  int sn [2] = '{3, 1};
  int pos [2];
  int sym [2];
  int ecnt [2];
  bit e_vld [2], e_sop [2], e_eop [2], e_slot [2], e_len [2], e_orph [2];
  int e_idx [2];
  logic [31:0] e_data;
  bit chk_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input int k);
    pos[k]++;
    e_vld[k] = 1'b1;
    e_sop[k] = (pos[k] == 1);
    e_idx[k] = sym[k];
    if (pos[k] == bl[k]) begin
      e_eop[k]  = 1'b1;
      e_slot[k] = (sym[k] == sn[k] - 1);
      sym[k]    = (sym[k] + 1) % sn[k];
      pos[k]    = 0;
    end
  endtask

  task automatic model(input int k);
    e_vld[k] = 0; e_sop[k] = 0; e_eop[k] = 0; e_slot[k] = 0; e_len[k] = 0; e_orph[k] = 0;
    if (rst) begin
      pos[k] = 0; sym[k] = 0; ecnt[k] = 0; e_idx[k] = 0;
    end else if (vld) begin
      if (sop) begin
        if (pos[k] != 0) begin
          e_len[k] = 1'b1;
          ecnt[k]++;
          sym[k] = (sym[k] + 1) % sn[k];
        end
        pos[k] = 0;
        accept(k);
      end else if (pos[k] == 0) begin
        e_orph[k] = 1'b1;
        ecnt[k]++;
      end else begin
        accept(k);
      end
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int k);
    int c;
    c = (ecnt[k] > 65535) ? 65535 : ecnt[k];
    return ERR_EN ? 32'(c) : 32'd0;
  endfunction

  task automatic step(input bit r, input bit v, input bit s, input logic [31:0] d);
    rst = r; vld = v; sop = s; din = d;
    model(0);
    model(1);
    e_data = r ? 32'd0 : d;
    @(posedge clk);
    #1;
    chk("a_vld", 32'(a_vld), 32'(e_vld[0]));
    chk("a_sop", 32'(a_sop), 32'(e_sop[0]));
    chk("a_eop", 32'(a_eop), 32'(e_eop[0]));
    chk("a_slot_done", 32'(a_slot), 32'(e_slot[0]));
    chk("a_len_err", 32'(a_len), 32'(e_len[0]));
    chk("a_orphan_err", 32'(a_orph), 32'(e_orph[0]));
    chk("a_err_cnt", 32'(a_ecnt), exp_cnt(0));
    chk("b_vld", 32'(b_vld), 32'(e_vld[1]));
    chk("b_sop", 32'(b_sop), 32'(e_sop[1]));
    chk("b_eop", 32'(b_eop), 32'(e_eop[1]));
    chk("b_slot_done", 32'(b_slot), 32'(e_slot[1]));
    chk("b_len_err", 32'(b_len), 32'(e_len[1]));
    chk("b_orphan_err", 32'(b_orph), 32'(e_orph[1]));
    chk("b_err_cnt", 32'(b_ecnt), exp_cnt(1));
    if (e_vld[0] || r) begin
      chk("a_data", a_data, e_data);
      chk("a_sym_idx", 32'(a_idx), 32'(e_idx[0]));
    end
    if (e_vld[1] || r) begin
      chk("b_data", b_data, e_data);
      chk("b_sym_idx", 32'(b_idx), 32'(e_idx[1]));
    end
  endtask

  task automatic burst(input int n);
    for (int w = 0; w < n; w++) step(0, 1, w == 0, $urandom);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sop = 1'b0; din = '0;
    // Reset state
    step(1, 0, 0, 32'h0);
    step(1, 1, 1, 32'hDEAD_BEEF);
    step(0, 0, 0, 32'h0);

    // Four back-to-back bursts: indices 0,1,2 then wrap to 0
    for (int b = 0; b < 4; b++) burst(4);

    // Burst with a 5-cycle valid gap after word 2
    step(1, 0, 0, 32'h0);
    step(0, 1, 1, $urandom);
    step(0, 1, 0, $urandom);
    for (int g = 0; g < 5; g++) step(0, 0, 0, $urandom);
    step(0, 1, 0, $urandom);
    step(0, 1, 0, $urandom);

    // Truncated burst: sop + 2 words, then a new sop
    step(1, 0, 0, 32'h0);
    burst(3);
    burst(4);

    // Orphans after reset, then a normal burst
    step(1, 0, 0, 32'h0);
    for (int o = 0; o < 3; o++) step(0, 1, 0, $urandom);
    burst(4);

    // Reset mid-burst, then orphans and a fresh burst
    step(1, 0, 0, 32'h0);
    burst(2);
    step(1, 1, 0, $urandom);
    step(0, 1, 0, $urandom);
    step(0, 1, 0, $urandom);
    burst(4);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
